// File: rtl/tl_monitor_pkg.sv
// Shared definitions for the TileLink source monitor and its assert modules.
//   SOURCE_W(n)   : width of a source ID able to name n sources.
//   tl_mon_err_e  : violation kinds, used by the assert modules' messages.
package tl_monitor_pkg;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_A_DUP    = 2'd1,
        ERR_D_ORPHAN = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } tl_mon_err_e;

    // Width of a source ID field; at least one bit even for a single source.
    function automatic int SOURCE_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tl_source_age.sv
// Per-source tracking slice: in-flight bit, saturating age counter and a
// sticky "timeout reported" bit.
//   clock, reset   : clock and asynchronous active-high reset
//   set            : allocate this source (age restarts at 0)
//   clear          : retire this source (applied before set when both high)
//   inflight       : registered in-flight bit
//   inflight_next  : value inflight will take at the next edge
//   timeout        : high in the cycle whose edge brings the age to TIMEOUT
module tl_source_age #(
    parameter int TIMEOUT = 1023,
    parameter int AGE_W   = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic set,
    input  logic clear,
    output logic inflight,
    output logic inflight_next,
    output logic timeout
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_HIT = AGE_W'(TIMEOUT - 1);

    logic             inflight_r;
    logic [AGE_W-1:0] age_r;
    logic             reported_r;
    logic             inflight_nx_s;
    logic [AGE_W-1:0] age_nx_s;
    logic             reported_nx_s;
    logic             hit_s;

    // A source retired on the same edge never reports; the sticky bit makes
    // the report a single pulse even while the age sits saturated.
    assign hit_s = inflight_r & ~clear & ~reported_r & (age_r == AGE_HIT);

    // Next-state: set wins over clear (retire-then-allocate), else age.
    always_comb begin
        inflight_nx_s = inflight_r;
        age_nx_s      = age_r;
        reported_nx_s = reported_r;
        if (set) begin
            inflight_nx_s = 1'b1;
            age_nx_s      = '0;
            reported_nx_s = 1'b0;
        end else if (clear) begin
            inflight_nx_s = 1'b0;
            age_nx_s      = '0;
            reported_nx_s = 1'b0;
        end else if (inflight_r) begin
            if (age_r != AGE_MAX) begin
                age_nx_s = age_r + AGE_W'(1);
            end else begin
                age_nx_s = age_r;
            end
            reported_nx_s = reported_r | hit_s;
        end else begin
            inflight_nx_s = inflight_r;
        end
    end

    // Slice state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_r <= 1'b0;
            age_r      <= '0;
            reported_r <= 1'b0;
        end else begin
            inflight_r <= inflight_nx_s;
            age_r      <= age_nx_s;
            reported_r <= reported_nx_s;
        end
    end

    assign inflight      = inflight_r;
    assign inflight_next = inflight_nx_s;
    assign timeout       = hit_s;

endmodule

// File: rtl/tl_source_monitor.sv
// TileLink source monitor: tracks in-flight A-channel sources, retires them
// on the last D beat, and raises registered violation pulses.
//   clock, reset        : clock and asynchronous active-high reset
//   a_valid/a_ready/a_source           : A-channel handshake and source ID
//   d_valid/d_ready/d_source/d_last    : D-channel handshake, source, last beat
//   inflight, inflight_count, idle     : outstanding-source bitmap and count
//   err_a_dup, err_d_orphan, err_timeout : one-cycle violation pulses
//   check_ok            : no violation this cycle
module tl_source_monitor
    import tl_monitor_pkg::*;
#(
    parameter int SOURCES = 8,
    parameter int TIMEOUT = 1023,
    parameter int AGE_W   = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          a_valid,
    input  logic                          a_ready,
    input  logic [SOURCE_W(SOURCES)-1:0]  a_source,
    input  logic                          d_valid,
    input  logic                          d_ready,
    input  logic [SOURCE_W(SOURCES)-1:0]  d_source,
    input  logic                          d_last,
    output logic [SOURCES-1:0]            inflight,
    output logic [SOURCE_W(SOURCES):0]    inflight_count,
    output logic                          idle,
    output logic                          err_a_dup,
    output logic                          err_d_orphan,
    output logic                          err_timeout,
    output logic                          check_ok
);

    localparam int SW = SOURCE_W(SOURCES);
    localparam int CW = SW + 1;

    logic               a_fire_s;
    logic               d_fire_s;
    logic [SOURCES-1:0] retire_vec_s;
    logic [SOURCES-1:0] set_vec_s;
    logic [SOURCES-1:0] inflight_s;
    logic [SOURCES-1:0] inflight_next_s;
    logic [SOURCES-1:0] timeout_vec_s;
    logic               a_dup_s;
    logic               d_orphan_s;
    logic               timeout_any_s;
    logic [CW-1:0]      count_nx_s;

    logic [CW-1:0]      count_r;
    logic               idle_r;
    logic               err_a_dup_r;
    logic               err_d_orphan_r;
    logic               err_timeout_r;
    logic               check_ok_r;

    function automatic logic [CW-1:0] popcount(input logic [SOURCES-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < SOURCES; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    assign a_fire_s = a_valid & a_ready;
    assign d_fire_s = d_valid & d_ready;

    // Source decoders. A duplicate A does not re-allocate, so its age keeps
    // running; an A on a source retiring this same edge is a legal reuse.
    always_comb begin
        retire_vec_s = '0;
        set_vec_s    = '0;
        for (int i = 0; i < SOURCES; i++) begin
            retire_vec_s[i] = d_fire_s & d_last & (d_source == SW'(i)) & inflight_s[i];
            set_vec_s[i]    = a_fire_s & (a_source == SW'(i))
                              & (~inflight_s[i] | retire_vec_s[i]);
        end
    end

    // Violation detection against the pre-update bitmap.
    assign a_dup_s       = a_fire_s & inflight_s[a_source] & ~retire_vec_s[a_source];
    assign d_orphan_s    = d_fire_s & ~inflight_s[d_source];
    assign timeout_any_s = |timeout_vec_s;
    assign count_nx_s    = popcount(inflight_next_s);

    genvar g;
    generate
        for (g = 0; g < SOURCES; g++) begin : g_src
            tl_source_age #(
                .TIMEOUT (TIMEOUT),
                .AGE_W   (AGE_W)
            ) u_age (
                .clock         (clock),
                .reset         (reset),
                .set           (set_vec_s[g]),
                .clear         (retire_vec_s[g]),
                .inflight      (inflight_s[g]),
                .inflight_next (inflight_next_s[g]),
                .timeout       (timeout_vec_s[g])
            );
        end
    endgenerate

    // Output registers: count, idle and the violation pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r        <= '0;
            idle_r         <= 1'b1;
            err_a_dup_r    <= 1'b0;
            err_d_orphan_r <= 1'b0;
            err_timeout_r  <= 1'b0;
            check_ok_r     <= 1'b1;
        end else begin
            count_r        <= count_nx_s;
            idle_r         <= (count_nx_s == CW'(0));
            err_a_dup_r    <= a_dup_s;
            err_d_orphan_r <= d_orphan_s;
            err_timeout_r  <= timeout_any_s;
            check_ok_r     <= ~(a_dup_s | d_orphan_s | timeout_any_s);
        end
    end

    assign inflight       = inflight_s;
    assign inflight_count = count_r;
    assign idle           = idle_r;
    assign err_a_dup      = err_a_dup_r;
    assign err_d_orphan   = err_d_orphan_r;
    assign err_timeout    = err_timeout_r;
    assign check_ok       = check_ok_r;

endmodule
